tff_sync_up_counter: RTL and testbench

- Synchronous, parameterised up counter built from T flip-flop cells; the up-counting companion to the team's 4-bit down ripple counter.
- All bits share one clock, so there is no ripple skew. Q is valid one cycle after any count, load or reset edge.
- Used as the up-direction timebase and as a cascadable prescaler stage: CARRY of one stage drives T of the next.

---
 rtl/tff_sync_up_counter_pkg.sv | 30 +++
 rtl/tff_sync_up_counter_tff_cell.sv | 30 +++
 rtl/tff_sync_up_counter.sv | 102 ++++++++++
 tb/tb_tff_sync_up_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tff_sync_up_counter_pkg.sv
// Shared constants and next-count arithmetic for the T flip-flop counter family.
// Optional feature macro used by the counters: UP_COUNTER_OVF_STICKY_EN.
package tff_sync_up_counter_pkg;

    localparam int CNT_WIDTH_DEF = 4;
    localparam int CNT_MOD_DEF   = 16;

    // Next value of an up count modulo `modulus`, wrapping modulus-1 -> 0.
    function automatic logic [31:0] cnt_next_mod(input logic [31:0] cur, input logic [31:0] modulus);
        logic [31:0] nxt;
        if (cur == modulus - 32'd1) begin
            nxt = 32'd0;
        end else begin
            nxt = cur + 32'd1;
        end
        return nxt;
    endfunction

    // Clamp a parallel-load value: values outside the modulus range load as zero.
    function automatic logic [31:0] cnt_load_val(input logic [31:0] val, input logic [31:0] modulus);
        logic [31:0] res;
        if (val < modulus) begin
            res = val;
        end else begin
            res = 32'd0;
        end
        return res;
    endfunction

endpackage

// File: rtl/tff_sync_up_counter_tff_cell.sv
// Single T flip-flop with synchronous active-high reset; toggles on rising CLK when T=1.
module tff_cell (
    input  logic CLK,
    input  logic RESET,
    input  logic T,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        if (T) begin
            q_d = ~q_q;
        end else begin
            q_d = q_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign Q = q_q;

endmodule

// File: rtl/tff_sync_up_counter.sv
// Synchronous modulo-MODULUS up counter built from WIDTH T flip-flop cells.
// Define UP_COUNTER_OVF_STICKY_EN to add the sticky OVF flag and its CLR_OVF input.
module tff_sync_up_counter
    import tff_sync_up_counter_pkg::*;
#(
    parameter int WIDTH   = CNT_WIDTH_DEF,
    parameter int MODULUS = CNT_MOD_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             T,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
`ifdef UP_COUNTER_OVF_STICKY_EN
    input  logic             CLR_OVF,
    output logic             OVF,
`endif
    output logic             CARRY
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] next_q_s;
    logic [WIDTH-1:0] toggle_s;
    logic             wrap_s;
    logic             carry_q;
    logic             carry_d;

    // Next-count selection: LOAD beats T beats hold; reset is applied inside the cells.
    always_comb begin
        next_q_s = q_s;
        wrap_s   = 1'b0;
        if (LOAD) begin
            next_q_s = WIDTH'(cnt_load_val(32'(D), 32'(MODULUS)));
        end else if (T) begin
            wrap_s   = (q_s == MAX_Q);
            next_q_s = WIDTH'(cnt_next_mod(32'(q_s), 32'(MODULUS)));
        end else begin
            next_q_s = q_s;
        end
        carry_d = wrap_s;
    end

    // A bit toggles exactly where the current and next counts differ.
    assign toggle_s = q_s ^ next_q_s;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            tff_cell u_cell (
                .CLK  (CLK),
                .RESET(RESET),
                .T    (toggle_s[gi]),
                .Q    (q_s[gi])
            );
        end
    endgenerate

    // Wrap pulse, visible in the cycle the count returns to zero.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

`ifdef UP_COUNTER_OVF_STICKY_EN
    logic ovf_q;
    logic ovf_d;

    // Sticky overflow: a wrap sets it and takes precedence over a same-cycle clear.
    always_comb begin
        if (wrap_s) begin
            ovf_d = 1'b1;
        end else if (CLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Overflow flag register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

    assign Q     = q_s;
    assign CARRY = carry_q;
    assign TC    = T && (q_s == MAX_Q);

endmodule

// File: tb/tb_tff_sync_up_counter.sv
// Scoreboard bench: two counters (MODULUS 16 and 10) share stimulus; a monitor checks every cycle.
module tb_tff_sync_up_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       t = 1'b0;
    logic       load = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] d = 4'd0;

    logic [3:0] q16, q10;
    logic       tc16, tc10, c16, c10;
`ifdef UP_COUNTER_OVF_STICKY_EN
    logic       ovf16, ovf10;
`endif

    always #5 clk = ~clk;

    tff_sync_up_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .CLK(clk), .RESET(rst), .T(t), .LOAD(load), .D(d), .Q(q16), .TC(tc16),
`ifdef UP_COUNTER_OVF_STICKY_EN
        .CLR_OVF(clr), .OVF(ovf16),
`endif
        .CARRY(c16)
    );

    tff_sync_up_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
        .CLK(clk), .RESET(rst), .T(t), .LOAD(load), .D(d), .Q(q10), .TC(tc10),
`ifdef UP_COUNTER_OVF_STICKY_EN
        .CLR_OVF(clr), .OVF(ovf10),
`endif
        .CARRY(c10)
    );

    typedef struct {
        int q;
        bit carry;
        bit tc;
        bit ovf;
    } exp_t;

    exp_t sb16[$];
    exp_t sb10[$];
    int   total = 0;
    int   bad = 0;

    int   m16_q = 0;
    int   m10_q = 0;
    bit   m16_ovf = 1'b0;
    bit   m10_ovf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, want, $time);
        end
    endtask

    // Reference behaviour for one rising edge, from the counter's rules in plain integers.
    task automatic model_step(input int m, input bit r, input bit l, input bit tt, input bit c,
                              input int dv, inout int mq, inout bit movf, output exp_t e);
        bit wrap;
        wrap = 1'b0;
        if (r) begin
            mq = 0;
        end else if (l) begin
            mq = (dv < m) ? dv : 0;
        end else if (tt) begin
            wrap = (mq == m - 1);
            mq = (mq + 1) % m;
        end
        if (r) movf = 1'b0;
        else if (wrap) movf = 1'b1;
        else if (c) movf = 1'b0;
        e.q = mq;
        e.carry = wrap;
        e.tc = tt && (mq == m - 1);
        e.ovf = movf;
    endtask

    task automatic drive(input bit r, input bit l, input bit tt, input bit c, input int dv);
        exp_t e;
        @(negedge clk);
        rst = r; load = l; t = tt; clr = c; d = dv[3:0];
        model_step(16, r, l, tt, c, dv, m16_q, m16_ovf, e);
        sb16.push_back(e);
        model_step(10, r, l, tt, c, dv, m10_q, m10_ovf, e);
        sb10.push_back(e);
    endtask

    task automatic run(input int n, input bit tt);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, tt, 1'b0, 0);
    endtask

    // Monitor: one expectation per edge, compared just after the edge settles.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb16.size() > 0) begin
            e = sb16.pop_front();
            chk("m16_q", 32'(q16), 32'(e.q));
            chk("m16_carry", 32'(c16), 32'(e.carry));
            chk("m16_tc", 32'(tc16), 32'(e.tc));
`ifdef UP_COUNTER_OVF_STICKY_EN
            chk("m16_ovf", 32'(ovf16), 32'(e.ovf));
`endif
        end
        if (sb10.size() > 0) begin
            e = sb10.pop_front();
            chk("m10_q", 32'(q10), 32'(e.q));
            chk("m10_carry", 32'(c10), 32'(e.carry));
            chk("m10_tc", 32'(tc10), 32'(e.tc));
            chk("m10_range", 32'(q10 < 4'd10), 32'd1);
`ifdef UP_COUNTER_OVF_STICKY_EN
            chk("m10_ovf", 32'(ovf10), 32'(e.ovf));
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset then a full cycle and a bit: wrap on both moduli.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(17, 1'b1);
        // Load 13 with T high (illegal for modulus 10), then count through the wrap.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 13);
        run(4, 1'b1);
        // Load 12, illegal for modulus 10.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 12);
        // Reset beats load.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 3);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 5);
        // Count to 7, then hold for 5 edges.
        run(7, 1'b1);
        run(5, 1'b0);
        // Load top value with T high: no wrap, TC immediately.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 15);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 9);
        run(2, 1'b1);
        // Reset mid-count with T high, then resume.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(6, 1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0, 0);
        run(3, 1'b1);
        // Sticky overflow: wrap, hold 20 cycles, clear, then wrap coinciding with clear.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 0);
        run(16, 1'b1);
        run(20, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
        run(15, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 0);
        run(2, 1'b0);
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, 15)));
        end
        run(2, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("sb16_drained", 32'(sb16.size()), 32'd0);
        chk("sb10_drained", 32'(sb10.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
